// File: rtl/mux2_pkg.sv
// Shared types and defaults for the arbitrated 2:1 selection stage
// (mux2_rr_arbiter) and its helpers.
package mux2_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 8;

  // Source identity; the encoding doubles as the downstream mux select.
  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_t;

  // Packet-lock state; only IDLE is ever reached when packet lock is not built in.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOCK_A = 2'd1,
    ST_LOCK_B = 2'd2
  } state_t;

  // The source that gets priority after the given one has been served.
  function automatic src_t other_src(input src_t s);
    return (s == SRC_A) ? SRC_B : SRC_A;
  endfunction

endpackage

// File: rtl/mux2_rr_arbiter_if.sv
// Handshake bundle for mux2_rr_arbiter: two valid/ready source channels in,
// one registered valid/ready channel plus mux select out.
// Optional macro MUX2_ARB_PKT_LOCK_EN adds the per-channel last flags.
interface mux2_rr_arbiter_if #(
  parameter int WIDTH = mux2_pkg::DEF_WIDTH
);

  logic             in_valid_a;
  logic [WIDTH-1:0] in_data_a;
  logic             in_ready_a;
  logic             in_valid_b;
  logic [WIDTH-1:0] in_data_b;
  logic             in_ready_b;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_sel;
  logic             out_ready;
`ifdef MUX2_ARB_PKT_LOCK_EN
  logic             in_last_a;
  logic             in_last_b;
  logic             out_last;

  // Arbiter side.
  modport slave (
    input  in_valid_a, in_data_a, in_last_a,
    input  in_valid_b, in_data_b, in_last_b,
    input  out_ready,
    output in_ready_a, in_ready_b,
    output out_valid, out_data, out_sel, out_last
  );

  // Environment side: sources and downstream sink.
  modport master (
    output in_valid_a, in_data_a, in_last_a,
    output in_valid_b, in_data_b, in_last_b,
    output out_ready,
    input  in_ready_a, in_ready_b,
    input  out_valid, out_data, out_sel, out_last
  );
`else
  // Arbiter side.
  modport slave (
    input  in_valid_a, in_data_a,
    input  in_valid_b, in_data_b,
    input  out_ready,
    output in_ready_a, in_ready_b,
    output out_valid, out_data, out_sel
  );

  // Environment side: sources and downstream sink.
  modport master (
    output in_valid_a, in_data_a,
    output in_valid_b, in_data_b,
    output out_ready,
    input  in_ready_a, in_ready_b,
    input  out_valid, out_data, out_sel
  );
`endif

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter: counts inc pulses and sticks at all-ones.
module sat_counter #(
  parameter int CNT_W = mux2_pkg::DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;

  // Count up on inc until every bit is set, then hold.
  // NOTE: clocked state is written only with non-blocking assignments so every
  // flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (inc && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/mux2_rr_arbiter.sv
// mux2_rr_arbiter: round-robin arbiter for two valid/ready sources feeding a
// one-beat output register and the downstream 2:1 mux select (0=A, 1=B).
// A new beat is taken whenever the output slot is empty or drains this cycle,
// giving one beat per clock at full throughput.
// Optional macro MUX2_ARB_PKT_LOCK_EN: keeps a source granted until it sends
// its last beat (packet lock).
module mux2_rr_arbiter
  import mux2_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  mux2_rr_arbiter_if.slave  bus,
  output logic [CNT_W-1:0]  cnt_a,
  output logic [CNT_W-1:0]  cnt_b
);

  state_t           r_state;
  src_t             r_prio;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  src_t             r_out_sel;
`ifdef MUX2_ARB_PKT_LOCK_EN
  logic             r_out_last;
  logic             w_acc_last;
`endif

  logic             w_slot_free;
  logic             w_elig_a;
  logic             w_elig_b;
  logic             w_grant_a;
  logic             w_grant_b;
  logic             w_acc_a;
  logic             w_acc_b;
  logic             w_accept;
  src_t             w_acc_src;
  logic [WIDTH-1:0] w_acc_data;
  state_t           w_next_state;

  // The slot can take a beat if it is empty or its beat leaves this cycle.
  assign w_slot_free = !r_out_valid || bus.out_ready;

  // A locked packet excludes the other source entirely.
  assign w_elig_a = bus.in_valid_a && (r_state != ST_LOCK_B);
  assign w_elig_b = bus.in_valid_b && (r_state != ST_LOCK_A);

  // A lone eligible source always wins; on contention prio decides.
  assign w_grant_a = w_elig_a && (!w_elig_b || (r_prio == SRC_A));
  assign w_grant_b = w_elig_b && (!w_elig_a || (r_prio == SRC_B));

  // Ready depends on valid (through the grant), never the other way round.
  assign bus.in_ready_a = w_slot_free && w_grant_a;
  assign bus.in_ready_b = w_slot_free && w_grant_b;

  assign w_acc_a    = bus.in_valid_a && bus.in_ready_a;
  assign w_acc_b    = bus.in_valid_b && bus.in_ready_b;
  assign w_accept   = w_acc_a || w_acc_b;
  assign w_acc_src  = w_acc_b ? SRC_B : SRC_A;
  assign w_acc_data = w_acc_b ? bus.in_data_b : bus.in_data_a;

`ifdef MUX2_ARB_PKT_LOCK_EN
  assign w_acc_last = w_acc_b ? bus.in_last_b : bus.in_last_a;
`endif

  // Lock transitions: a non-last beat locks onto its source, a last beat unlocks.
  // NOTE: the default assignment at the top keeps this block latch-free on
  // every path, including the build where no transition is ever taken.
  always_comb begin
    w_next_state = r_state;
`ifdef MUX2_ARB_PKT_LOCK_EN
    if (w_acc_a) begin
      w_next_state = bus.in_last_a ? ST_IDLE : ST_LOCK_A;
    end else if (w_acc_b) begin
      w_next_state = bus.in_last_b ? ST_IDLE : ST_LOCK_B;
    end
`endif
  end

  // Control FSM and output register: capture on accept, drain when taken.
  // NOTE: the data register is reset along with the control bits so the
  // downstream mux sees a defined word and select out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_prio      <= SRC_A;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= SRC_A;
`ifdef MUX2_ARB_PKT_LOCK_EN
      r_out_last  <= 1'b0;
`endif
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_acc_data;
        r_out_sel   <= w_acc_src;
        r_prio      <= other_src(w_acc_src);
`ifdef MUX2_ARB_PKT_LOCK_EN
        r_out_last  <= w_acc_last;
`endif
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_sel   = r_out_sel;
`ifdef MUX2_ARB_PKT_LOCK_EN
  assign bus.out_last  = r_out_last;
`endif

  // Per-source grant statistics, saturating rather than wrapping.
  sat_counter #(.CNT_W(CNT_W)) u_cnt_a (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_acc_a),
    .count (cnt_a)
  );

  sat_counter #(.CNT_W(CNT_W)) u_cnt_b (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_acc_b),
    .count (cnt_b)
  );

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Self-checking bench for mux2_rr_arbiter: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model. A second
// instance with 2-bit counters runs on the same stimulus to exercise saturation.
// Honours MUX2_ARB_PKT_LOCK_EN when defined.
module tb_mux2_rr_arbiter;
  import mux2_pkg::*;

  localparam int WIDTH  = 8;
  localparam int CNT_W  = 8;
  localparam int CNT_W2 = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mux2_rr_arbiter_if #(.WIDTH(WIDTH)) ifc ();
  mux2_rr_arbiter_if #(.WIDTH(WIDTH)) ifc2 ();

  logic [CNT_W-1:0]  cnt_a, cnt_b;
  logic [CNT_W2-1:0] cnt2_a, cnt2_b;

  mux2_rr_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk (clk), .rst_n (rst_n), .bus (ifc), .cnt_a (cnt_a), .cnt_b (cnt_b)
  );

  mux2_rr_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W2)) dut_sat (
    .clk (clk), .rst_n (rst_n), .bus (ifc2), .cnt_a (cnt2_a), .cnt_b (cnt2_b)
  );

  assign ifc2.in_valid_a = ifc.in_valid_a;
  assign ifc2.in_data_a  = ifc.in_data_a;
  assign ifc2.in_valid_b = ifc.in_valid_b;
  assign ifc2.in_data_b  = ifc.in_data_b;
  assign ifc2.out_ready  = ifc.out_ready;
`ifdef MUX2_ARB_PKT_LOCK_EN
  assign ifc2.in_last_a  = ifc.in_last_a;
  assign ifc2.in_last_b  = ifc.in_last_b;
`endif

  int n_checks = 0;
  int n_err    = 0;

  // Behavioural model: what the output slot holds and who is owed priority.
  bit         m_valid;
  logic [7:0] m_data;
  bit         m_sel;
  bit         m_last;
  bit         m_prio;     // 0: A preferred on contention, 1: B
  int         m_lock;     // 0: none, 1: locked to A, 2: locked to B
  int         m_cnt_a, m_cnt_b;

  // Values observed in the most recent step (sampled mid-cycle).
  logic       obs_ra, obs_rb, obs_valid, obs_sel, obs_last;
  logic [7:0] obs_data;
  logic [31:0] obs_cnt_a, obs_cnt_b, obs_cnt2_a;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  function automatic int sat(input int v, input int max_v);
    return (v > max_v) ? max_v : v;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_data = '0; m_sel = 0; m_last = 0;
    m_prio = 0; m_lock = 0; m_cnt_a = 0; m_cnt_b = 0;
  endtask

  // Asynchronous reset applied between edges; literal reset values checked.
  task automatic do_reset();
    ifc.in_valid_a = 1'b1; ifc.in_valid_b = 1'b1; ifc.out_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", ifc.out_valid, 0);
    check("rst_out_data", ifc.out_data, 0);
    check("rst_out_sel", ifc.out_sel, 0);
    check("rst_cnt_a", cnt_a, 0);
    check("rst_cnt_b", cnt_b, 0);
    check("rst_cnt2_b", cnt2_b, 0);
    check("rst_sat_valid", ifc2.out_valid, 0);
`ifdef MUX2_ARB_PKT_LOCK_EN
    check("rst_out_last", ifc.out_last, 0);
`endif
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock: drive inputs at the falling edge, compare against the model,
  // advance the model by what the rising edge must do.
  task automatic step(input logic va, input logic [7:0] da, input logic vb,
                      input logic [7:0] db, input logic la, input logic lb,
                      input logic ordy);
    bit slot, ga, gb, eff_la, eff_lb;
    ifc.in_valid_a = va; ifc.in_data_a = da;
    ifc.in_valid_b = vb; ifc.in_data_b = db;
    ifc.out_ready  = ordy;
`ifdef MUX2_ARB_PKT_LOCK_EN
    ifc.in_last_a = la; ifc.in_last_b = lb;
    eff_la = la; eff_lb = lb;
`else
    eff_la = 1; eff_lb = 1;
    if (la !== lb) eff_la = 1;  // last flags are meaningless without packet lock
`endif
    #1;
    slot = !m_valid || ordy;
    ga = 0; gb = 0;
    if (slot) begin
      if (m_lock == 1)            ga = va;
      else if (m_lock == 2)       gb = vb;
      else if (va && vb)          begin ga = !m_prio; gb = m_prio; end
      else                        begin ga = va; gb = vb; end
    end

    obs_ra = ifc.in_ready_a; obs_rb = ifc.in_ready_b;
    obs_valid = ifc.out_valid; obs_data = ifc.out_data; obs_sel = ifc.out_sel;
    obs_cnt_a = 32'(cnt_a); obs_cnt_b = 32'(cnt_b); obs_cnt2_a = 32'(cnt2_a);
`ifdef MUX2_ARB_PKT_LOCK_EN
    obs_last = ifc.out_last;
    check("out_last", obs_last, m_last);
`else
    obs_last = 1'b1;
`endif
    check("in_ready_a", obs_ra, ga);
    check("in_ready_b", obs_rb, gb);
    check("one_ready", obs_ra & obs_rb, 0);
    check("out_valid", obs_valid, m_valid);
    check("out_data", obs_data, m_data);
    check("out_sel", obs_sel, m_sel);
    check("cnt_a", obs_cnt_a, sat(m_cnt_a, 255));
    check("cnt_b", obs_cnt_b, sat(m_cnt_b, 255));
    check("cnt2_a", obs_cnt2_a, sat(m_cnt_a, 3));
    check("cnt2_b", cnt2_b, sat(m_cnt_b, 3));
    check("sat_out_data", ifc2.out_data, m_data);

    if (ga) begin
      m_valid = 1; m_data = da; m_sel = 0; m_last = eff_la;
      m_cnt_a++; m_prio = 1; m_lock = eff_la ? 0 : 1;
    end else if (gb) begin
      m_valid = 1; m_data = db; m_sel = 1; m_last = eff_lb;
      m_cnt_b++; m_prio = 0; m_lock = eff_lb ? 0 : 2;
    end else if (ordy) begin
      m_valid = 0;
    end
    @(negedge clk);
  endtask

  logic [7:0] exp_seq [6] = '{8'h11, 8'h22, 8'h11, 8'h22, 8'h11, 8'h22};

  initial begin
    ifc.in_valid_a = 0; ifc.in_valid_b = 0; ifc.in_data_a = 0; ifc.in_data_b = 0;
    ifc.out_ready = 1;
`ifdef MUX2_ARB_PKT_LOCK_EN
    ifc.in_last_a = 1; ifc.in_last_b = 1;
`endif
    @(negedge clk);
    do_reset();

    // Round robin under contention: A first, then strict alternation.
    for (int i = 0; i < 7; i++) begin
      step(i < 6, 8'h11, i < 6, 8'h22, 1, 1, 1);
      if (i == 0) begin
        check("first_ready_a", obs_ra, 1);
        check("first_ready_b", obs_rb, 0);
      end else begin
        check("rr_valid", obs_valid, 1);
        check("rr_data", obs_data, exp_seq[i-1]);
        if (i == 1) check("rr_first_sel", obs_sel, 0);
      end
    end
    check("rr_cnt_a", obs_cnt_a, 3);
    check("rr_cnt_b", obs_cnt_b, 3);

    // Backpressure: held beat stable, no readies, released exactly once.
    step(1, 8'h5A, 0, 8'h00, 1, 1, 1);
    for (int i = 0; i < 4; i++) begin
      step(1, 8'h66, 1, 8'h77, 1, 1, 0);
      check("stall_ready_a", obs_ra, 0);
      check("stall_ready_b", obs_rb, 0);
      check("stall_data", obs_data, 8'h5A);
      check("stall_sel", obs_sel, 0);
    end
    step(0, 8'h00, 0, 8'h00, 1, 1, 1);
    check("release_valid", obs_valid, 1);
    check("release_data", obs_data, 8'h5A);
    step(0, 8'h00, 0, 8'h00, 1, 1, 1);
    check("release_once", obs_valid, 0);

    // Lone B source back-to-back, then A wins the first contention.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(0, 8'h00, 1, 8'(8'h30 + i), 1, 1, 1);
      check("b_only_ready", obs_rb, 1);
    end
    step(1, 8'h40, 1, 8'h41, 1, 1, 1);
    check("after_b_ready_a", obs_ra, 1);
    check("after_b_ready_b", obs_rb, 0);
    check("b_only_cnt_b", obs_cnt_b, 5);
    check("b_only_last_data", obs_data, 8'h34);
    for (int i = 0; i < 6; i++) step(1, 8'(8'h50 + i), 0, 8'h00, 1, 1, 1);
    step(0, 8'h00, 0, 8'h00, 1, 1, 1);
    check("a_cnt_wide", obs_cnt_a, 7);
    check("a_cnt_saturated", obs_cnt2_a, 3);

    // Randomized traffic with a reset in the middle.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 3) != 0,
           8'($urandom), $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 3) != 0);
    end

`ifdef MUX2_ARB_PKT_LOCK_EN
    // Packet lock: 3-beat A packet holds off B, then B is served.
    do_reset();
    step(1, 8'hA1, 1, 8'hB0, 0, 1, 1);
    check("pkt_ready_a0", obs_ra, 1);
    step(1, 8'hA2, 1, 8'hB0, 0, 1, 1);
    check("pkt_ready_b1", obs_rb, 0);
    step(1, 8'hA3, 1, 8'hB0, 1, 1, 1);
    check("pkt_ready_b2", obs_rb, 0);
    check("pkt_data2", obs_data, 8'hA2);
    step(0, 8'h00, 1, 8'hB0, 1, 1, 1);
    check("pkt_ready_b3", obs_rb, 1);
    check("pkt_data3", obs_data, 8'hA3);
    check("pkt_last3", obs_last, 1);
    // Reset mid-packet must drop the lock.
    step(1, 8'hC1, 1, 8'hB1, 0, 1, 1);
    do_reset();
    step(0, 8'h00, 1, 8'hBB, 1, 1, 1);
    check("unlock_after_rst", obs_rb, 1);
    check("unlock_valid", obs_valid, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
